idu: RTL

IDU -- requirements
Module: idu

---
 rtl/idu.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/idu.sv
// Instruction decode stage: RV64I decoder, load-use hazard detection and
// the ID/EX pipeline register.
module idu (
   input  logic        clk,
   input  logic        rstn,
   input  logic        update,
   input  logic [63:0] ifu_pc,
   input  logic [63:0] ifu_snxt_pc,
   input  logic [31:0] ifu_instr,
   input  logic        ifu_valid,
   input  logic        flush_nop,
   input  logic [4:0]  exu_rd,
   input  logic        exu_mem_read,
   input  logic        exu_valid,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   output logic        hazard_stop,
   output logic [63:0] idu_pc,
   output logic [63:0] idu_snxt_pc,
   output logic [63:0] idu_rs1,
   output logic [63:0] idu_rs2,
   output logic [63:0] idu_imm,
   output logic [4:0]  idu_rd,
   output logic [3:0]  idu_alu_op,
   output logic        idu_word,
   output logic        idu_mem_read,
   output logic        idu_mem_write,
   output logic        idu_reg_write,
   output logic        idu_is_branch,
   output logic        idu_is_jump,
   output logic        idu_ebreak,
   output logic        idu_illegal,
   output logic        idu_valid
);

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OPIMM  = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_OPIMMW = 7'b0011011,
      OPC_OPW    = 7'b0111011,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
   } alu_op_e;

   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rd;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   logic [63:0] d_imm;
   logic [3:0]  d_alu;
   logic        d_word, d_mr, d_mw, d_wr, d_br, d_jp, d_eb, d_ill;
   logic        use_rs1, use_rs2;

   assign f3       = ifu_instr[14:12];
   assign f7       = ifu_instr[31:25];
   assign rd       = ifu_instr[11:7];
   assign rs1_addr = ifu_instr[19:15];
   assign rs2_addr = ifu_instr[24:20];

   assign imm_i = {{52{ifu_instr[31]}}, ifu_instr[31:20]};
   assign imm_s = {{52{ifu_instr[31]}}, ifu_instr[31:25], ifu_instr[11:7]};
   assign imm_b = {{51{ifu_instr[31]}}, ifu_instr[31], ifu_instr[7],
                   ifu_instr[30:25], ifu_instr[11:8], 1'b0};
   assign imm_u = {{32{ifu_instr[31]}}, ifu_instr[31:12], 12'b0};
   assign imm_j = {{43{ifu_instr[31]}}, ifu_instr[31], ifu_instr[19:12],
                   ifu_instr[20], ifu_instr[30:21], 1'b0};

   always_comb begin
      d_imm   = '0;
      d_alu   = ALU_ADD;
      d_word  = 1'b0;
      d_mr    = 1'b0;
      d_mw    = 1'b0;
      d_wr    = 1'b0;
      d_br    = 1'b0;
      d_jp    = 1'b0;
      d_eb    = 1'b0;
      d_ill   = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (ifu_instr[6:0])
         OPC_LUI: begin
            d_imm = imm_u; d_alu = ALU_PASSB; d_wr = 1'b1;
         end
         OPC_AUIPC: begin
            d_imm = imm_u; d_wr = 1'b1;
         end
         OPC_JAL: begin
            d_imm = imm_j; d_wr = 1'b1; d_jp = 1'b1;
         end
         OPC_JALR: begin
            d_imm = imm_i; d_wr = 1'b1; d_jp = 1'b1; use_rs1 = 1'b1;
            d_ill = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            d_imm = imm_b; d_alu = ALU_SUB; d_br = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            d_imm = imm_i; d_mr = 1'b1; d_wr = 1'b1; use_rs1 = 1'b1;
            d_ill = (f3 == 3'b111);
         end
         OPC_STORE: begin
            d_imm = imm_s; d_mw = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            d_ill = f3[2];
         end
         OPC_OPIMM: begin
            d_imm = imm_i; d_wr = 1'b1; use_rs1 = 1'b1;
            case (f3)
               3'b000: d_alu = ALU_ADD;
               3'b010: d_alu = ALU_SLT;
               3'b011: d_alu = ALU_SLTU;
               3'b100: d_alu = ALU_XOR;
               3'b110: d_alu = ALU_OR;
               3'b111: d_alu = ALU_AND;
               3'b001: begin
                  d_alu = ALU_SLL;
                  d_ill = (ifu_instr[31:26] != 6'b000000);
               end
               default: begin
                  // RV64 shamt is 6 bits, so only instr[31:26] is funct
                  d_alu = ifu_instr[30] ? ALU_SRA : ALU_SRL;
                  d_ill = (ifu_instr[31:26] != 6'b000000) &&
                          (ifu_instr[31:26] != 6'b010000);
               end
            endcase
         end
         OPC_OP: begin
            d_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'b000:  d_alu = f7[5] ? ALU_SUB : ALU_ADD;
               3'b001:  d_alu = ALU_SLL;
               3'b010:  d_alu = ALU_SLT;
               3'b011:  d_alu = ALU_SLTU;
               3'b100:  d_alu = ALU_XOR;
               3'b101:  d_alu = f7[5] ? ALU_SRA : ALU_SRL;
               3'b110:  d_alu = ALU_OR;
               default: d_alu = ALU_AND;
            endcase
            if ((f3 == 3'b000) || (f3 == 3'b101))
               d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            else
               d_ill = (f7 != 7'b0000000);
         end
         OPC_OPIMMW: begin
            d_imm = imm_i; d_wr = 1'b1; d_word = 1'b1; use_rs1 = 1'b1;
            case (f3)
               3'b000: d_alu = ALU_ADD;
               3'b001: begin
                  d_alu = ALU_SLL;
                  d_ill = (f7 != 7'b0000000);
               end
               3'b101: begin
                  d_alu = f7[5] ? ALU_SRA : ALU_SRL;
                  d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               default: d_ill = 1'b1;
            endcase
         end
         OPC_OPW: begin
            d_wr = 1'b1; d_word = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            case (f3)
               3'b000: begin
                  d_alu = f7[5] ? ALU_SUB : ALU_ADD;
                  d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               3'b001: begin
                  d_alu = ALU_SLL;
                  d_ill = (f7 != 7'b0000000);
               end
               3'b101: begin
                  d_alu = f7[5] ? ALU_SRA : ALU_SRL;
                  d_ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
               end
               default: d_ill = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            d_imm   = imm_i;
            use_rs1 = 1'b1;
            d_eb    = (ifu_instr == 32'h0010_0073);
            d_ill   = !d_eb;
         end
         default: d_ill = 1'b1;
      endcase
      // illegal instructions travel as valid but side-effect free
      if (d_ill) begin
         d_wr = 1'b0; d_mr = 1'b0; d_mw = 1'b0;
         d_br = 1'b0; d_jp = 1'b0; d_eb = 1'b0;
      end
      if (rd == 5'd0)
         d_wr = 1'b0;
   end

   assign hazard_stop = ifu_valid && exu_valid && exu_mem_read && (exu_rd != 5'd0) &&
                        (((exu_rd == rs1_addr) && use_rs1) ||
                         ((exu_rd == rs2_addr) && use_rs2));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         idu_pc        <= '0;
         idu_snxt_pc   <= '0;
         idu_rs1       <= '0;
         idu_rs2       <= '0;
         idu_imm       <= '0;
         idu_rd        <= '0;
         idu_alu_op    <= '0;
         idu_word      <= 1'b0;
         idu_mem_read  <= 1'b0;
         idu_mem_write <= 1'b0;
         idu_reg_write <= 1'b0;
         idu_is_branch <= 1'b0;
         idu_is_jump   <= 1'b0;
         idu_ebreak    <= 1'b0;
         idu_illegal   <= 1'b0;
         idu_valid     <= 1'b0;
      end else if (update) begin
         idu_pc      <= ifu_pc;
         idu_snxt_pc <= ifu_snxt_pc;
         idu_rs1     <= rs1_data;
         idu_rs2     <= rs2_data;
         idu_imm     <= d_imm;
         idu_alu_op  <= d_alu;
         idu_word    <= d_word;
         if (flush_nop || hazard_stop || !ifu_valid) begin
            idu_rd        <= '0;
            idu_mem_read  <= 1'b0;
            idu_mem_write <= 1'b0;
            idu_reg_write <= 1'b0;
            idu_is_branch <= 1'b0;
            idu_is_jump   <= 1'b0;
            idu_ebreak    <= 1'b0;
            idu_illegal   <= 1'b0;
            idu_valid     <= 1'b0;
         end else begin
            idu_rd        <= rd;
            idu_mem_read  <= d_mr;
            idu_mem_write <= d_mw;
            idu_reg_write <= d_wr;
            idu_is_branch <= d_br;
            idu_is_jump   <= d_jp;
            idu_ebreak    <= d_eb;
            idu_illegal   <= d_ill;
            idu_valid     <= 1'b1;
         end
      end
   end

endmodule
